// File: rtl/fetch_stage.sv
// Y86-64 style fetch stage: one outstanding instruction-memory request feeding a
// single-entry instruction buffer, with mispredict/ret redirect and a halt state.
module fetch_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        F_stall_i,
   input  logic [3:0]  M_icode_i,
   input  logic        M_Cnd_i,
   input  logic [63:0] M_valA_i,
   input  logic [3:0]  W_icode_i,
   input  logic [63:0] W_valM_i,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [79:0] imem_rdata_i,
   input  logic        imem_err_i,
   output logic [3:0]  f_icode_o,
   output logic [3:0]  f_ifun_o,
   output logic [3:0]  f_rA_o,
   output logic [3:0]  f_rB_o,
   output logic [63:0] f_valC_o,
   output logic [63:0] f_valP_o,
   output logic [2:0]  f_stat_o,
   output logic        f_valid_o,
   output logic        f_busy_o
);

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic [2:0] {IDLE, REQ, READY, DROP, HALTED} state_t;

   state_t      state, state_nxt;
   logic [63:0] pc_q;
   logic [63:0] drop_addr;
   logic [79:0] ibuf;
   logic        ibuf_err;

   logic        redirect;
   logic [63:0] target;

   logic [3:0]  icode, ifun, ra, rb;
   logic        need_regids, need_valc, inst_ok;
   logic [63:0] valc, valp, pred_pc;
   logic [2:0]  stat;

   // Mispredicted jump outranks ret.
   always_comb begin
      redirect = 1'b0;
      target   = '0;
      if (M_icode_i == 4'h7 && !M_Cnd_i) begin
         redirect = 1'b1;
         target   = M_valA_i;
      end else if (W_icode_i == 4'h9) begin
         redirect = 1'b1;
         target   = W_valM_i;
      end
   end

   // A bus error replaces the fetched bytes with a nop-shaped instruction.
   always_comb begin
      icode       = ibuf_err ? 4'h1 : ibuf[7:4];
      ifun        = ibuf_err ? 4'h0 : ibuf[3:0];
      inst_ok     = (icode <= 4'hB);
      need_regids = 1'b0;
      need_valc   = 1'b0;
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: need_regids = 1'b1;
         4'h3, 4'h4, 4'h5: begin
            need_regids = 1'b1;
            need_valc   = 1'b1;
         end
         4'h7, 4'h8: need_valc = 1'b1;
         default: ;
      endcase
      ra = need_regids ? ibuf[15:12] : 4'hF;
      rb = need_regids ? ibuf[11:8]  : 4'hF;
      if (!need_valc)      valc = '0;
      else if (need_regids) valc = ibuf[79:16];
      else                 valc = ibuf[71:8];
      valp = pc_q + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
      pred_pc = (icode == 4'h7 || icode == 4'h8) ? valc : valp;
      if (ibuf_err)          stat = SADR;
      else if (!inst_ok)     stat = SINS;
      else if (icode == 4'h0) stat = SHLT;
      else                   stat = SAOK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   state_nxt = REQ;
         REQ: begin
            if (redirect)        state_nxt = imem_ack_i ? REQ : DROP;
            else if (imem_ack_i) state_nxt = READY;
         end
         DROP:   if (imem_ack_i) state_nxt = REQ;
         READY: begin
            if (redirect)        state_nxt = REQ;
            else if (!F_stall_i) state_nxt = (stat != SAOK) ? HALTED : REQ;
         end
         HALTED: if (redirect) state_nxt = REQ;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      imem_req_o  = (state == REQ) || (state == DROP);
      imem_addr_o = (state == DROP) ? drop_addr : pc_q;
      f_valid_o   = (state == READY);
      f_busy_o    = !f_valid_o;
      f_icode_o   = 4'h1;
      f_ifun_o    = 4'h0;
      f_rA_o      = 4'hF;
      f_rB_o      = 4'hF;
      f_valC_o    = '0;
      f_valP_o    = '0;
      f_stat_o    = SAOK;
      if (state == READY) begin
         f_icode_o = icode;
         f_ifun_o  = ifun;
         f_rA_o    = ra;
         f_rB_o    = rb;
         f_valC_o  = valc;
         f_valP_o  = valp;
         f_stat_o  = stat;
      end
   end

   // drop_addr keeps the abandoned request's address stable while pc_q moves on.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= '0;
         drop_addr <= '0;
         ibuf      <= '0;
         ibuf_err  <= 1'b0;
      end else begin
         case (state)
            REQ: begin
               if (redirect) begin
                  pc_q <= target;
                  if (!imem_ack_i) drop_addr <= pc_q;
               end else if (imem_ack_i) begin
                  ibuf     <= imem_rdata_i;
                  ibuf_err <= imem_err_i;
               end
            end
            DROP: if (redirect) pc_q <= target;
            READY: begin
               if (redirect) begin
                  pc_q     <= target;
                  ibuf     <= '0;
                  ibuf_err <= 1'b0;
               end else if (!F_stall_i) begin
                  pc_q <= pred_pc;
               end
            end
            HALTED: if (redirect) pc_q <= target;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear scenario sequence with hand-computed values.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        F_stall_i = 1'b0;
   logic [3:0]  M_icode_i = 4'h0;
   logic        M_Cnd_i = 1'b0;
   logic [63:0] M_valA_i = '0;
   logic [3:0]  W_icode_i = 4'h0;
   logic [63:0] W_valM_i = '0;
   logic        imem_req_o;
   logic [63:0] imem_addr_o;
   logic        imem_ack_i = 1'b0;
   logic [79:0] imem_rdata_i = '0;
   logic        imem_err_i = 1'b0;
   logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o;
   logic [63:0] f_valC_o, f_valP_o;
   logic [2:0]  f_stat_o;
   logic        f_valid_o, f_busy_o;

   int total = 0;
   int fails = 0;

   fetch_stage dut (
      .clk(clk), .rst(rst), .F_stall_i(F_stall_i),
      .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i), .M_valA_i(M_valA_i),
      .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
      .f_icode_o(f_icode_o), .f_ifun_o(f_ifun_o), .f_rA_o(f_rA_o), .f_rB_o(f_rB_o),
      .f_valC_o(f_valC_o), .f_valP_o(f_valP_o), .f_stat_o(f_stat_o),
      .f_valid_o(f_valid_o), .f_busy_o(f_busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, "_valid"}, {63'd0, f_valid_o}, 64'd0);
      chk({tag, "_busy"},  {63'd0, f_busy_o},  64'd1);
      chk({tag, "_icode"}, {60'd0, f_icode_o}, 64'h1);
      chk({tag, "_rA"},    {60'd0, f_rA_o},    64'hF);
      chk({tag, "_valP"},  f_valP_o,           64'd0);
      chk({tag, "_stat"},  {61'd0, f_stat_o},  64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      // Reset state
      step();
      chk("rst_req", {63'd0, imem_req_o}, 64'd0);
      chk_bubble("rst");
      rst = 1'b1;
      #1;
      chk("idle_req", {63'd0, imem_req_o}, 64'd0);
      step();
      chk("first_req", {63'd0, imem_req_o}, 64'd1);
      chk("first_addr", imem_addr_o, 64'd0);

      // irmovq $8, %rbx : 30 F3 08 00..
      step();
      chk("hold_req", {63'd0, imem_req_o}, 64'd1);
      chk("hold_addr", imem_addr_o, 64'd0);
      imem_ack_i = 1'b1; imem_rdata_i = 80'h08F330;
      step();
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      chk("irm_valid", {63'd0, f_valid_o}, 64'd1);
      chk("irm_busy", {63'd0, f_busy_o}, 64'd0);
      chk("irm_req", {63'd0, imem_req_o}, 64'd0);
      chk("irm_icode", {60'd0, f_icode_o}, 64'h3);
      chk("irm_ifun", {60'd0, f_ifun_o}, 64'h0);
      chk("irm_rA", {60'd0, f_rA_o}, 64'hF);
      chk("irm_rB", {60'd0, f_rB_o}, 64'h3);
      chk("irm_valC", f_valC_o, 64'h8);
      chk("irm_valP", f_valP_o, 64'hA);
      chk("irm_stat", {61'd0, f_stat_o}, 64'd1);

      // Stall for 3 cycles; a stray ack must be ignored
      F_stall_i = 1'b1;
      imem_ack_i = 1'b1; imem_rdata_i = 80'h00C0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", {63'd0, f_valid_o}, 64'd1);
         chk("stall_req", {63'd0, imem_req_o}, 64'd0);
         chk("stall_icode", {60'd0, f_icode_o}, 64'h3);
         chk("stall_valP", f_valP_o, 64'hA);
      end
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      F_stall_i = 1'b0;
      step();
      chk("consume_req", {63'd0, imem_req_o}, 64'd1);
      chk("consume_addr", imem_addr_o, 64'hA);
      chk("consume_valid", {63'd0, f_valid_o}, 64'd0);

      // jmp 0x40 at 0, then mispredict back to 9
      do_reset();
      chk("jmp_addr0", imem_addr_o, 64'd0);
      imem_ack_i = 1'b1; imem_rdata_i = 80'h4070;
      step();
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      chk("jmp_icode", {60'd0, f_icode_o}, 64'h7);
      chk("jmp_rA", {60'd0, f_rA_o}, 64'hF);
      chk("jmp_valC", f_valC_o, 64'h40);
      chk("jmp_valP", f_valP_o, 64'h9);
      step();
      chk("jmp_pred_addr", imem_addr_o, 64'h40);
      M_icode_i = 4'h7; M_Cnd_i = 1'b1; M_valA_i = 64'h9;
      step();
      chk("taken_no_redirect", imem_addr_o, 64'h40);
      M_Cnd_i = 1'b0;
      imem_ack_i = 1'b1; imem_rdata_i = 80'h10;
      step();
      M_icode_i = 4'h0; M_valA_i = '0;
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      chk("mispred_req", {63'd0, imem_req_o}, 64'd1);
      chk("mispred_addr", imem_addr_o, 64'h9);
      chk("mispred_valid", {63'd0, f_valid_o}, 64'd0);

      // Redirect while request outstanding -> DROP
      do_reset();
      M_icode_i = 4'h7; M_Cnd_i = 1'b0; M_valA_i = 64'h100;
      step();
      M_icode_i = 4'h0; M_valA_i = '0;
      chk("drop_req", {63'd0, imem_req_o}, 64'd1);
      chk("drop_addr", imem_addr_o, 64'd0);
      step();
      chk("drop_hold_addr", imem_addr_o, 64'd0);
      chk("drop_valid", {63'd0, f_valid_o}, 64'd0);
      imem_ack_i = 1'b1; imem_rdata_i = 80'h10;
      step();
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      chk("drop_done_addr", imem_addr_o, 64'h100);
      chk("drop_done_valid", {63'd0, f_valid_o}, 64'd0);

      // halt at 0x100
      imem_ack_i = 1'b1; imem_rdata_i = 80'h00;
      step();
      imem_ack_i = 1'b0;
      chk("halt_stat", {61'd0, f_stat_o}, 64'd2);
      chk("halt_icode", {60'd0, f_icode_o}, 64'h0);
      chk("halt_valP", f_valP_o, 64'h101);
      step();
      chk("halted_req", {63'd0, imem_req_o}, 64'd0);
      chk("halted_valid", {63'd0, f_valid_o}, 64'd0);
      step();
      chk("halted_req2", {63'd0, imem_req_o}, 64'd0);
      W_icode_i = 4'h9; W_valM_i = 64'h20;
      step();
      W_icode_i = 4'h0; W_valM_i = '0;
      chk("ret_req", {63'd0, imem_req_o}, 64'd1);
      chk("ret_addr", imem_addr_o, 64'h20);

      // Bus error -> SADR
      imem_ack_i = 1'b1; imem_err_i = 1'b1; imem_rdata_i = 80'h30;
      step();
      imem_ack_i = 1'b0; imem_err_i = 1'b0; imem_rdata_i = '0;
      chk("err_stat", {61'd0, f_stat_o}, 64'd3);
      chk("err_icode", {60'd0, f_icode_o}, 64'h1);
      chk("err_ifun", {60'd0, f_ifun_o}, 64'h0);
      step();
      chk("err_halted_req", {63'd0, imem_req_o}, 64'd0);
      // Both redirect sources: mispredict wins
      M_icode_i = 4'h7; M_Cnd_i = 1'b0; M_valA_i = 64'h30;
      W_icode_i = 4'h9; W_valM_i = 64'h99;
      step();
      M_icode_i = 4'h0; M_valA_i = '0; W_icode_i = 4'h0; W_valM_i = '0;
      chk("prio_addr", imem_addr_o, 64'h30);

      // Invalid opcode C0 -> SINS
      imem_ack_i = 1'b1; imem_rdata_i = 80'hC0;
      step();
      imem_ack_i = 1'b0; imem_rdata_i = '0;
      chk("ins_stat", {61'd0, f_stat_o}, 64'd4);
      chk("ins_icode", {60'd0, f_icode_o}, 64'hC);
      chk("ins_valP", f_valP_o, 64'h31);
      step();
      W_icode_i = 4'h9; W_valM_i = 64'h40;
      step();
      W_icode_i = 4'h0; W_valM_i = '0;
      chk("pre_rst_addr", imem_addr_o, 64'h40);

      // Reset mid-REQ acts immediately
      rst = 1'b0;
      #1;
      chk("async_rst_req", {63'd0, imem_req_o}, 64'd0);
      chk_bubble("async_rst");
      rst = 1'b1;
      step();
      chk("post_rst_req", {63'd0, imem_req_o}, 64'd1);
      chk("post_rst_addr", imem_addr_o, 64'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk is the only clock, and rst is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 F_stall_i  in  1  1 = decode register holds; buffered instruction not consumed.
REQ-005 M_icode_i  in  4, M_Cnd_i  in  1, M_valA_i  in  64  memory-stage jump info; M_valA_i = fall-through PC.
REQ-006 W_icode_i  in  4, W_valM_i  in  64  write-back-stage ret info; W_valM_i = return address.
REQ-007 imem_req_o  out  1, imem_addr_o  out  64  instruction-memory request and byte address.
REQ-008 imem_ack_i  in  1, imem_rdata_i  in  80, imem_err_i  in  1  response; byte k at imem_rdata_i[8k+7:8k].
REQ-009 f_icode_o, f_ifun_o, f_rA_o, f_rB_o  out  4 each  decoded fields to decode register.
REQ-010 f_valC_o  out  64, f_valP_o  out  64, f_stat_o  out  3  constant, next-sequential PC, status.
REQ-011 f_valid_o  out  1  buffered instruction present; f_busy_o  out  1  = !f_valid_o, to pipeline control.
REQ-012 Status codes SHALL be SAOK=1, SHLT=2, SADR=3, SINS=4.

Function
REQ-013 States SHALL be IDLE, REQ, READY, DROP and HALTED; pc_q (64 b) holds the current fetch address.
REQ-014 Redirect SHALL be raised when (M_icode_i=7 and M_Cnd_i=0), with target M_valA_i; otherwise when W_icode_i=9, with target W_valM_i; the mispredict has priority.
REQ-015 IDLE SHALL go to REQ on the next clk edge.
REQ-016 REQ SHALL drive imem_req_o=1 and imem_addr_o=pc_q, holding both stable until imem_ack_i=1.
REQ-017 REQ with ack and no redirect SHALL capture rdata and err into the buffer and go to READY.
REQ-018 REQ with redirect SHALL load pc_q=target; with ack in the same cycle, data is discarded and the state goes to REQ; without ack, the state goes to DROP.
REQ-019 DROP SHALL keep imem_req_o=1 at the old address until ack, discard the data, then go to REQ; a further redirect in DROP only updates pc_q.
REQ-020 READY SHALL drive f_valid_o=1 and imem_req_o=0; redirect in READY SHALL load pc_q=target, discard the buffer and go to REQ.
REQ-021 READY, no redirect, F_stall_i=1: state, buffer and outputs SHALL remain unchanged.
REQ-022 READY, no redirect, F_stall_i=0: the block SHALL load pc_q=predPC, then go to HALTED if f_stat_o≠SAOK, else to REQ.
REQ-023 HALTED SHALL drive imem_req_o=0 and f_valid_o=0; a redirect SHALL load pc_q=target and go to REQ.
REQ-024 Decode: icode=byte0[7:4], ifun=byte0[3:0]; instruction valid iff icode≤0xB.
REQ-025 need_regids SHALL be set for icode in {2,3,4,5,6,A,B}; need_valC for icode in {3,4,5,7,8}.
REQ-026 rA=byte1[7:4] and rB=byte1[3:0] when need_regids, else both 0xF.
REQ-027 valC SHALL be little-endian bytes 2..9 if need_regids, else bytes 1..8, when need_valC; otherwise 0.
REQ-028 valP SHALL be pc_q + 1 + need_regids + 8·need_valC, modulo 2^64.
REQ-029 predPC SHALL be valC for icode 7 or 8, else valP.
REQ-030 Stat priority SHALL be: err → SADR with icode=1, ifun=0; invalid → SINS; icode 0 → SHLT; else SAOK.
REQ-031 When f_valid_o=0, outputs SHALL be a bubble: icode=1, ifun=0, rA=rB=0xF, valC=0, valP=0, stat=SAOK.
REQ-032 imem_ack_i outside REQ and DROP SHALL be ignored.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, pc_q=0, buffer=0, imem_req_o=0, f_valid_o=0 and bubble outputs, including when asserted mid-REQ.
REQ-034 After rst rises, the first request SHALL be at address 0, one edge later.

Verification
REQ-035 Reset; ack after 2 cycles with bytes 30 F3 08 00.. → READY, icode 3, rA F, rB 3, valC 8, valP 0xA, SAOK; consume → next req at 0xA.
REQ-036 READY with F_stall_i=1 for 3 cycles → outputs stable, imem_req_o=0; release → pc_q=valP.
REQ-037 Bytes 70 40 00.. at 0 → valP 9, next address 0x40; then M_icode=7, M_Cnd=0, M_valA=9 → next request at 9.
REQ-038 Redirect to 0x100 while REQ is pending → DROP, old ack discarded, next request at 0x100, f_valid_o stays 0.
REQ-039 Byte 00 → SHLT, consumed → HALTED, no requests; W_icode=9, W_valM=0x20 → request at 0x20.
REQ-040 imem_err_i=1 with ack → SADR, icode 1; byte 0xC0 → SINS; rst low mid-REQ → bubble outputs immediately.
